// File: rtl/pc_pkg.sv
// Shared constants and types for the program counter.
// The optional misalignment flag is enabled by defining PC_ALIGN_CHECK_EN.
package pc_pkg;

    localparam int unsigned PC_WIDTH = 32;

    typedef logic [PC_WIDTH-1:0] pc_t;

    localparam pc_t         PC_RESET_VECTOR = 32'h0000_0000;
    localparam int unsigned PC_INC          = 4;

    // A PC is misaligned when either of its two low bits is set
    function automatic logic pc_is_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

endpackage : pc_pkg

// File: rtl/pc_incrementer.sv
// Combinational adder producing a + INC, wrapping modulo 2^WIDTH.
module pc_incrementer
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH = PC_WIDTH,
    parameter int unsigned INC   = PC_INC
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] sum
);

    // Carry out of the top bit is dropped so the result wraps silently
    assign sum = a + WIDTH'(INC);

endmodule : pc_incrementer

// File: rtl/program_counter.sv
// Program counter register with stall enable and next-sequential-PC adder.
// Define PC_ALIGN_CHECK_EN to build the registered misaligned flag;
// otherwise misaligned is tied to 0 and no flag register exists.
module program_counter
    import pc_pkg::*;
#(
    parameter int unsigned       WIDTH        = PC_WIDTH,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = WIDTH'(PC_RESET_VECTOR),
    parameter int unsigned       INC          = PC_INC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] pc_in,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus_inc,
    output logic             misaligned
);

    // PC (and optional alignment flag) register; reset is asynchronous, active-low
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_out     <= RESET_VECTOR;
`ifdef PC_ALIGN_CHECK_EN
            misaligned <= 1'b0;
`endif
        end else if (en) begin
            pc_out     <= pc_in;
`ifdef PC_ALIGN_CHECK_EN
            misaligned <= pc_is_misaligned(pc_in[1:0]);
`endif
        end
    end

`ifndef PC_ALIGN_CHECK_EN
    assign misaligned = 1'b0;
`endif

    // Sequential next-PC, purely from the registered PC
    pc_incrementer #(
        .WIDTH (WIDTH),
        .INC   (INC)
    ) u_incrementer (
        .a   (pc_out),
        .sum (pc_plus_inc)
    );

endmodule : program_counter

// File: tb/tb_program_counter.sv
// Directed, self-checking bench for program_counter. A behavioural model
// tracks the expected PC and is compared every falling clock edge; literal
// checks at fixed points pin the model to hand-computed values.
module tb_program_counter;

    logic        clk;
    logic        reset;
    logic        en;
    logic [31:0] pc_in;
    logic [31:0] pc_out;
    logic [31:0] pc_plus_inc;
    logic        misaligned;

    int n_checks = 0;
    int n_fail   = 0;

    program_counter #(
        .WIDTH        (32),
        .RESET_VECTOR (32'h0000_0000),
        .INC          (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .pc_in       (pc_in),
        .pc_out      (pc_out),
        .pc_plus_inc (pc_plus_inc),
        .misaligned  (misaligned)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the PC the spec says must be visible
    logic [31:0] m_pc;
    bit          m_valid = 1'b0;

    always @(negedge reset) begin
        m_pc    = 32'h0000_0000;
        m_valid = 1'b1;
    end

    always @(posedge clk) begin
        if (reset === 1'b1 && en === 1'b1)
            m_pc = pc_in;
    end

    function automatic logic [31:0] exp_plus(input logic [31:0] pc);
        longint unsigned s;
        s = (longint'(pc) + 4) % 64'h1_0000_0000;
        return 32'(s);
    endfunction

    function automatic logic exp_mis(input logic [31:0] pc);
`ifdef PC_ALIGN_CHECK_EN
        return (pc % 4) != 0;
`else
        return 1'b0;
`endif
    endfunction

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_pc_out", pc_out, m_pc);
            check("model_pc_plus_inc", pc_plus_inc, exp_plus(m_pc));
            check("model_misaligned", 32'(misaligned), 32'(exp_mis(m_pc)));
        end
    end

    // Set inputs, take one rising edge, settle 3 ns (away from both edges)
    task automatic drive(input logic e, input logic [31:0] d);
        en    = e;
        pc_in = d;
        @(posedge clk);
        #3;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected end before 100000 ns");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        pc_in = 32'h0;

        // Asynchronous reset assertion with no clock edge involved
        #2 reset = 1'b0;
        #1;
        check("reset_async_pc", pc_out, 32'h0);
        check("reset_async_mis", 32'(misaligned), 32'h0);

        // Edges, en and pc_in ignored while reset is low
        drive(1'b1, 32'h0000_0123);
        drive(1'b1, 32'h0000_0456);
        check("reset_ignores_load", pc_out, 32'h0);

        // Release away from an edge; first edge loads
        reset = 1'b1;
        drive(1'b1, 32'h4);
        check("load_4_pc", pc_out, 32'h4);
        check("load_4_plus", pc_plus_inc, 32'h8);
        drive(1'b1, 32'h8);
        check("load_8_pc", pc_out, 32'h8);
        check("load_8_plus", pc_plus_inc, 32'hC);

        // Mid-cycle reset clears before the next edge
        reset = 1'b0;
        pc_in = 32'hC;
        #1;
        check("midcycle_reset_pc", pc_out, 32'h0);
        @(posedge clk);
        #3;
        check("midcycle_reset_hold", pc_out, 32'h0);
        reset = 1'b1;
        drive(1'b1, 32'hC);
        check("post_reset_C", pc_out, 32'hC);
        drive(1'b1, 32'h10);
        check("post_reset_10", pc_out, 32'h10);

        // Stall for three cycles
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h40);
            check("stall_hold", pc_out, 32'h10);
        end
        drive(1'b1, 32'h40);
        check("stall_release", pc_out, 32'h40);

        // Wraparound of the incrementer
        drive(1'b1, 32'hFFFF_FFFC);
        check("wrap_pc", pc_out, 32'hFFFF_FFFC);
        check("wrap_plus", pc_plus_inc, 32'h0000_0000);

        // Verbatim load of a misaligned value
        drive(1'b1, 32'h6);
        check("misaligned_pc", pc_out, 32'h6);
        check("misaligned_plus", pc_plus_inc, 32'hA);
`ifdef PC_ALIGN_CHECK_EN
        check("misaligned_flag", 32'(misaligned), 32'h1);
`else
        check("misaligned_flag", 32'(misaligned), 32'h0);
`endif
        drive(1'b0, 32'h8);
`ifdef PC_ALIGN_CHECK_EN
        check("misaligned_flag_hold", 32'(misaligned), 32'h1);
`else
        check("misaligned_flag_hold", 32'(misaligned), 32'h0);
`endif
        drive(1'b1, 32'h8000_0001);
        check("odd_pc", pc_out, 32'h8000_0001);
        drive(1'b1, 32'h1234_5678);
        check("aligned_pc", pc_out, 32'h1234_5678);
        check("aligned_mis", 32'(misaligned), 32'h0);

        // Reset while a misaligned value is held clears the flag
        drive(1'b1, 32'h3);
        reset = 1'b0;
        #1;
        check("reset_clears_pc", pc_out, 32'h0);
        check("reset_clears_mis", 32'(misaligned), 32'h0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        drive(1'b1, 32'h20);
        check("final_load", pc_out, 32'h20);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_program_counter
